execute_muldiv: RTL

Iterative RV32M multiply/divide unit in the execute stage, consuming the operand bundle (register data, destination register, M-extension op select) held by the decode/execute pipeline register. It accepts one operation at a time, holds `busy` while it computes, and drives the pipeline stall. It returns a single-cycle result pulse with the destination register for the execute/memory register to capture. Latency is fixed and data-independent, so hazard logic and the bench can predict it exactly.

---
 rtl/execute_muldiv_if.sv | 27 ++
 rtl/execute_muldiv.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/execute_muldiv_if.sv
// Operand/result bundle between the decode/execute register and the
// iterative multiply/divide unit.
interface execute_muldiv_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic [4:0]      in_rd;
  logic            flush;

  logic            busy;
  logic            result_valid;
  logic [XLEN-1:0] result;
  logic [4:0]      result_rd;

  modport master (
    output in_valid, in_funct3, in_rs1_data, in_rs2_data, in_rd, flush,
    input  busy, result_valid, result, result_rd
  );

  modport slave (
    input  in_valid, in_funct3, in_rs1_data, in_rs2_data, in_rd, flush,
    output busy, result_valid, result, result_rd
  );
endinterface

// File: rtl/execute_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Fixed occupancy: accept, 32 shift iterations, one result cycle.
module execute_muldiv #(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  execute_muldiv_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [4:0]      count;
  logic [2:0]      op_funct3;
  logic [4:0]      op_rd;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            neg_result;
  logic            div_zero;
  logic            div_ovf;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;

  logic            result_valid_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      result_rd_q;

  logic accept;
  logic finish;

  assign accept = (state == IDLE) && bus.in_valid && !bus.flush;
  assign finish = (state == RUN) && (count == 5'd31) && !bus.flush;

  // Operand sign decode: which operands are signed, their magnitudes, and
  // the sign the final result must carry.
  logic            a_signed;
  logic            b_signed;
  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            neg_in;
  logic            zero_in;
  logic            ovf_in;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (bus.in_funct3)
      3'd1, 3'd4, 3'd6: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      3'd2: a_signed = 1'b1;
      default: begin
        a_signed = 1'b0;
        b_signed = 1'b0;
      end
    endcase

    sign_a = a_signed && bus.in_rs1_data[XLEN-1];
    sign_b = b_signed && bus.in_rs2_data[XLEN-1];
    abs_a  = sign_a ? -bus.in_rs1_data : bus.in_rs1_data;
    abs_b  = sign_b ? -bus.in_rs2_data : bus.in_rs2_data;

    // Remainder follows the dividend; products and quotients follow sA^sB.
    if (bus.in_funct3[2] && bus.in_funct3[1]) begin
      neg_in = sign_a;
    end else begin
      neg_in = sign_a ^ sign_b;
    end

    zero_in = (bus.in_rs2_data == '0);
    ovf_in  = !bus.in_funct3[0] && bus.in_funct3[2] &&
              (bus.in_rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
              (bus.in_rs2_data == '1);
  end

  // One radix-2 step of each core per cycle; both run, the op picks one.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod_step;
  logic [XLEN:0]     rem_trial;
  logic [XLEN+1:0]   rem_diff;
  logic [XLEN-1:0]   rem_step;
  logic [XLEN-1:0]   quo_step;
  logic              div_unused;

  always_comb begin
    mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mag_a} : '0);
    prod_step = {mul_sum, prod[XLEN-1:1]};

    rem_trial = {rem, quo[XLEN-1]};
    rem_diff  = {1'b0, rem_trial} - {2'b00, mag_b};
    if (!rem_diff[XLEN+1]) begin
      rem_step = rem_diff[XLEN-1:0];
      quo_step = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_step = rem_trial[XLEN-1:0];
      quo_step = {quo[XLEN-2:0], 1'b0};
    end
  end

  // A restored remainder is always below the divisor, so bit XLEN is zero.
  assign div_unused = rem_diff[XLEN];

  // Final sign fix and special cases, evaluated on the last iteration so the
  // registered result is ready the cycle DONE is entered.
  logic [2*XLEN-1:0] prod_signed;
  logic [XLEN-1:0]   quo_signed;
  logic [XLEN-1:0]   rem_signed;
  logic [XLEN-1:0]   final_result;

  always_comb begin
    prod_signed  = neg_result ? -prod_step : prod_step;
    quo_signed   = neg_result ? -quo_step  : quo_step;
    rem_signed   = neg_result ? -rem_step  : rem_step;
    final_result = '0;
    case (op_funct3)
      3'd0:             final_result = prod_signed[XLEN-1:0];
      3'd1, 3'd2, 3'd3: final_result = prod_signed[2*XLEN-1:XLEN];
      3'd4, 3'd5: begin
        if (div_zero) begin
          final_result = '1;
        end else if (div_ovf) begin
          final_result = {1'b1, {(XLEN-1){1'b0}}};
        end else begin
          final_result = quo_signed;
        end
      end
      default: begin
        // With a zero divisor the core already hands back the dividend.
        if (div_ovf && !div_zero) begin
          final_result = '0;
        end else begin
          final_result = rem_signed;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_next = IDLE;
        end else if (count == 5'd31) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count          <= '0;
      op_funct3      <= '0;
      op_rd          <= '0;
      mag_a          <= '0;
      mag_b          <= '0;
      neg_result     <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      prod           <= '0;
      quo            <= '0;
      rem            <= '0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      result_rd_q    <= '0;
    end else begin
      result_valid_q <= 1'b0;
      if (accept) begin
        count      <= '0;
        op_funct3  <= bus.in_funct3;
        op_rd      <= bus.in_rd;
        mag_a      <= abs_a;
        mag_b      <= abs_b;
        neg_result <= neg_in;
        div_zero   <= zero_in;
        div_ovf    <= ovf_in;
        prod       <= {{XLEN{1'b0}}, abs_b};
        quo        <= abs_a;
        rem        <= '0;
      end else if (state == RUN) begin
        count <= count + 5'd1;
        prod  <= prod_step;
        quo   <= quo_step;
        rem   <= rem_step;
      end
      if (finish) begin
        result_valid_q <= 1'b1;
        result_q       <= final_result;
        result_rd_q    <= op_rd;
      end
    end
  end

  assign bus.busy         = (state != IDLE);
  assign bus.result_valid = result_valid_q;
  assign bus.result       = result_q;
  assign bus.result_rd    = result_rd_q;

endmodule
